// File: rtl/proc_defs.sv
// Shared definitions for the processor control unit: instruction field
// layout, opcodes, write-back select encodings, FSM states and the decoded
// control payload handed from the decoder to the sequencer.
package proc_defs;

  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned OP_W     = 4;
  localparam int unsigned REG_W    = 3;
  localparam int unsigned ALU_OP_W = 3;
  localparam int unsigned DEST_W   = 2;

  // Field positions; imm overlaps ry/alu_op and is only meaningful for LDI/JMP/JZ
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RX_LSB  = 9;
  localparam int unsigned RY_LSB  = 6;
  localparam int unsigned ALU_LSB = 3;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_LDI = 4'h1;
  localparam logic [OP_W-1:0] OP_MOV = 4'h2;
  localparam logic [OP_W-1:0] OP_ALU = 4'h3;
  localparam logic [OP_W-1:0] OP_JMP = 4'h4;
  localparam logic [OP_W-1:0] OP_JZ  = 4'h5;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  // Write-back mux select
  localparam logic [DEST_W-1:0] DEST_DATAIN = 2'b00;
  localparam logic [DEST_W-1:0] DEST_DATA_A = 2'b01;
  localparam logic [DEST_W-1:0] DEST_ALU    = 2'b10;
  localparam logic [DEST_W-1:0] DEST_DATA_B = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_HALT    = 3'd4
  } stateT;

  typedef struct packed {
    logic [REG_W-1:0]    rx;
    logic [REG_W-1:0]    ry;
    logic [ALU_OP_W-1:0] selOp;
    logic [DEST_W-1:0]   destSrc;
    logic [DATA_W-1:0]   dataIn;
    logic                writes;
  } ctrlT;

  function automatic logic [OP_W-1:0] fieldOp(input logic [INSTR_W-1:0] i);
    return i[OP_LSB +: OP_W];
  endfunction

  function automatic logic [REG_W-1:0] fieldRx(input logic [INSTR_W-1:0] i);
    return i[RX_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] fieldRy(input logic [INSTR_W-1:0] i);
    return i[RY_LSB +: REG_W];
  endfunction

  function automatic logic [ALU_OP_W-1:0] fieldAlu(input logic [INSTR_W-1:0] i);
    return i[ALU_LSB +: ALU_OP_W];
  endfunction

  function automatic logic [DATA_W-1:0] fieldImm(input logic [INSTR_W-1:0] i);
    return i[IMM_LSB +: DATA_W];
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder.
// Ports:
//   instr      in   latched 16-bit instruction
//   ctrl_c     out  register selects, ALU op, write-back select, immediate, write flag
//   isJmp_c    out  unconditional jump
//   isJz_c     out  jump-if-zero on datapath output
//   isHlt_c    out  halt
//   illegal_c  out  undefined opcode (executes as NOP)
module instr_decoder
  import proc_defs::*;
(
  input  logic [INSTR_W-1:0] instr,
  output ctrlT               ctrl_c,
  output logic               isJmp_c,
  output logic               isJz_c,
  output logic               isHlt_c,
  output logic               illegal_c
);

  // Register selects pass straight through; op-specific fields on top
  always_comb begin
    ctrl_c    = '0;
    ctrl_c.rx = fieldRx(instr);
    ctrl_c.ry = fieldRy(instr);
    isJmp_c   = 1'b0;
    isJz_c    = 1'b0;
    isHlt_c   = 1'b0;
    illegal_c = 1'b0;
    unique case (fieldOp(instr))
      OP_NOP: ;
      OP_LDI: begin
        ctrl_c.writes  = 1'b1;
        ctrl_c.destSrc = DEST_DATAIN;
        ctrl_c.dataIn  = fieldImm(instr);
      end
      OP_MOV: begin
        ctrl_c.writes  = 1'b1;
        ctrl_c.destSrc = DEST_DATA_A;
      end
      OP_ALU: begin
        ctrl_c.writes  = 1'b1;
        ctrl_c.destSrc = DEST_ALU;
        ctrl_c.selOp   = fieldAlu(instr);
      end
      OP_JMP: isJmp_c = 1'b1;
      // Route Rx onto the write-back bus so data_w reflects it for the zero test
      OP_JZ: begin
        isJz_c         = 1'b1;
        ctrl_c.destSrc = DEST_DATA_B;
      end
      OP_HLT: isHlt_c = 1'b1;
      default: illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/proc_control_unit.sv
// Multi-cycle sequencer for the 8-bit datapath: fetches over req/ack,
// decodes, drives register-file/ALU/write-back controls, updates pc and
// counts retired instructions. All outputs are registered.
// Ports:
//   clock, reset              clock; asynchronous active-high reset
//   start                     leave IDLE/HALT and fetch from pc=0
//   fetch_req, pc             fetch request and instruction address
//   fetch_ack, instr          memory ack with instruction in the same cycle
//   data_w                    datapath write-back bus (JZ condition)
//   Rx, Ry, selOp, destSrc    datapath selects
//   regWrite, dataIn          register write enable and immediate
//   busy, halted, illegal     status
//   retired                   executed-instruction count
module proc_control_unit
  import proc_defs::*;
#(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  output logic                fetch_req,
  output logic [PC_W-1:0]     pc,
  input  logic                fetch_ack,
  input  logic [INSTR_W-1:0]  instr,
  input  logic [DATA_W-1:0]   data_w,
  output logic [REG_W-1:0]    Rx,
  output logic [REG_W-1:0]    Ry,
  output logic [ALU_OP_W-1:0] selOp,
  output logic [DEST_W-1:0]   destSrc,
  output logic                regWrite,
  output logic [DATA_W-1:0]   dataIn,
  output logic                busy,
  output logic                halted,
  output logic                illegal,
  output logic [CNT_W-1:0]    retired
);

  stateT                state, stateNext;
  logic [INSTR_W-1:0]   instrQ, instrNext;
  logic [PC_W-1:0]      pcNext;
  logic [CNT_W-1:0]     retiredNext;
  logic [REG_W-1:0]     rxNext, ryNext;
  logic [ALU_OP_W-1:0]  selOpNext;
  logic [DEST_W-1:0]    destSrcNext;
  logic [DATA_W-1:0]    dataInNext;
  logic                 regWriteNext, fetchReqNext, busyNext, haltedNext, illegalNext;

  ctrlT decCtrl;
  logic decJmp, decJz, decHlt, decIllegal;

  instr_decoder uDecoder (
    .instr     (instrQ),
    .ctrl_c    (decCtrl),
    .isJmp_c   (decJmp),
    .isJz_c    (decJz),
    .isHlt_c   (decHlt),
    .illegal_c (decIllegal)
  );

  // Next state and next registered outputs; outputs are derived from the
  // state being entered so they line up with the state they describe.
  always_comb begin
    stateNext    = state;
    instrNext    = instrQ;
    pcNext       = pc;
    retiredNext  = retired;
    rxNext       = Rx;
    ryNext       = Ry;
    selOpNext    = selOp;
    dataInNext   = dataIn;
    destSrcNext  = DEST_DATAIN;
    regWriteNext = 1'b0;
    fetchReqNext = 1'b0;
    busyNext     = 1'b0;
    haltedNext   = 1'b0;
    illegalNext  = 1'b0;
    unique case (state)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          stateNext    = ST_FETCH;
          pcNext       = '0;
          fetchReqNext = 1'b1;
          busyNext     = 1'b1;
        end else begin
          haltedNext = (state == ST_HALT);
        end
      end
      ST_FETCH: begin
        busyNext = 1'b1;
        if (fetch_ack) begin
          stateNext = ST_DECODE;
          instrNext = instr;
        end else begin
          fetchReqNext = 1'b1;
        end
      end
      ST_DECODE: begin
        stateNext    = ST_EXECUTE;
        busyNext     = 1'b1;
        rxNext       = decCtrl.rx;
        ryNext       = decCtrl.ry;
        selOpNext    = decCtrl.selOp;
        dataInNext   = decCtrl.dataIn;
        destSrcNext  = decCtrl.destSrc;
        regWriteNext = decCtrl.writes;
        illegalNext  = decIllegal;
      end
      ST_EXECUTE: begin
        retiredNext = retired + CNT_W'(1);
        if (decHlt) begin
          stateNext  = ST_HALT;
          haltedNext = 1'b1;
        end else begin
          stateNext    = ST_FETCH;
          fetchReqNext = 1'b1;
          busyNext     = 1'b1;
          if (decJmp || (decJz && (data_w == '0))) begin
            pcNext = PC_W'(fieldImm(instrQ));
          end else begin
            pcNext = pc + PC_W'(1);
          end
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      instrQ    <= '0;
      pc        <= '0;
      retired   <= '0;
      Rx        <= '0;
      Ry        <= '0;
      selOp     <= '0;
      destSrc   <= DEST_DATAIN;
      dataIn    <= '0;
      regWrite  <= 1'b0;
      fetch_req <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      state     <= stateNext;
      instrQ    <= instrNext;
      pc        <= pcNext;
      retired   <= retiredNext;
      Rx        <= rxNext;
      Ry        <= ryNext;
      selOp     <= selOpNext;
      destSrc   <= destSrcNext;
      dataIn    <= dataInNext;
      regWrite  <= regWriteNext;
      fetch_req <= fetchReqNext;
      busy      <= busyNext;
      halted    <= haltedNext;
      illegal   <= illegalNext;
    end
  end

endmodule

// File: tb/tb_proc_control_unit.sv
// Testbench for proc_control_unit: directed scenarios plus randomized
// instruction streams checked against an instruction-level model.
module tb_proc_control_unit;

  logic        clock = 1'b0;
  logic        reset, start, fetch_ack;
  logic [15:0] instr;
  logic [7:0]  data_w;
  logic        fetch_req, regWrite, busy, halted, illegal;
  logic [7:0]  pc, dataIn;
  logic [2:0]  Rx, Ry, selOp;
  logic [1:0]  destSrc;
  logic [15:0] retired;

  int checks = 0;
  int passes = 0;
  int mdlPc = 0;
  int mdlRetired = 0;

  typedef struct {
    logic        timeout, stallOk;
    logic [7:0]  pcFetch;
    logic        decRegWrite, decFetchReq;
    logic [2:0]  exRx, exRy, exSelOp;
    logic [1:0]  exDest;
    logic        exRegWrite, exIllegal, exBusy;
    logic [7:0]  exDataIn;
    logic [7:0]  afterPc;
    logic [15:0] afterRetired;
    logic        afterFetchReq, afterHalted, afterRegWrite, afterIllegal;
  } obsT;

  proc_control_unit #(.PC_W(8), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .start(start), .fetch_req(fetch_req), .pc(pc),
    .fetch_ack(fetch_ack), .instr(instr), .data_w(data_w), .Rx(Rx), .Ry(Ry),
    .selOp(selOp), .destSrc(destSrc), .regWrite(regWrite), .dataIn(dataIn),
    .busy(busy), .halted(halted), .illegal(illegal), .retired(retired)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Instruction-level reference rules
  function automatic int opOf(input logic [15:0] ins);
    return int'(ins) / 4096;
  endfunction

  function automatic int expNextPc(input logic [15:0] ins, input int curPc, input logic [7:0] dw);
    int op  = int'(ins) / 4096;
    int imm = int'(ins) % 256;
    if (op == 4) return imm;
    if (op == 5) return (dw == 8'd0) ? imm : (curPc + 1) % 256;
    if (op == 15) return curPc;
    return (curPc + 1) % 256;
  endfunction

  function automatic int expWrites(input int op);
    return (op >= 1 && op <= 3) ? 1 : 0;
  endfunction

  function automatic int expDest(input int op);
    case (op)
      1: return 0;
      2: return 1;
      3: return 2;
      5: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int expIllegal(input int op);
    return (op >= 6 && op <= 14) ? 1 : 0;
  endfunction

  // Drives one instruction through FETCH/DECODE/EXECUTE and records what the DUT showed
  task automatic doInstr(input logic [15:0] ins, input int stall, input logic [7:0] dw, output obsT ob);
    ob = '{default: '0};
    ob.stallOk = 1'b1;
    fetch_ack = 1'b0;
    instr = ins;
    for (int i = 0; i < 20; i++) begin
      if (fetch_req === 1'b1) break;
      step();
    end
    if (fetch_req !== 1'b1) begin
      ob.timeout = 1'b1;
      return;
    end
    ob.pcFetch = pc;
    for (int i = 0; i < stall; i++) begin
      step();
      if (fetch_req !== 1'b1 || pc !== ob.pcFetch || busy !== 1'b1) ob.stallOk = 1'b0;
    end
    fetch_ack = 1'b1;
    step();
    fetch_ack = 1'b0;
    instr = 16'($urandom);
    ob.decRegWrite = regWrite;
    ob.decFetchReq = fetch_req;
    data_w = dw;
    step();
    ob.exRx = Rx; ob.exRy = Ry; ob.exSelOp = selOp; ob.exDest = destSrc;
    ob.exRegWrite = regWrite; ob.exDataIn = dataIn; ob.exIllegal = illegal; ob.exBusy = busy;
    step();
    ob.afterPc = pc; ob.afterRetired = retired; ob.afterFetchReq = fetch_req;
    ob.afterHalted = halted; ob.afterRegWrite = regWrite; ob.afterIllegal = illegal;
    data_w = 8'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; fetch_ack = 1'b0; instr = 16'h0; data_w = 8'h0;
    repeat (2) step();
    checks++; if ({fetch_req, regWrite, busy, halted, illegal, destSrc, selOp, Rx, Ry, dataIn, pc, retired} !== 48'h0)
      $display("FAIL reset_outputs: got %0h want 0", {fetch_req, regWrite, busy, halted, illegal, destSrc, selOp, Rx, Ry, dataIn, pc, retired}); else passes++;
    reset = 1'b0;
    repeat (3) step();
    checks++; if ({fetch_req, busy, halted} !== 3'b000) $display("FAIL idle_no_start: got %b want 000", {fetch_req, busy, halted}); else passes++;
    mdlPc = 0; mdlRetired = 0;
  endtask

  task automatic test_ldi();
    obsT ob;
    pulseStart();
    checks++; if ({fetch_req, busy, pc} !== {1'b1, 1'b1, 8'h00}) $display("FAIL start_fetch: got %0h want 300", {fetch_req, busy, pc}); else passes++;
    doInstr(16'h145A, 0, 8'h33, ob);
    checks++; if (ob.timeout !== 1'b0) $display("FAIL ldi_timeout: got %b want 0", ob.timeout); else passes++;
    checks++; if (ob.decRegWrite !== 1'b0) $display("FAIL ldi_decode_regwrite: got %b want 0", ob.decRegWrite); else passes++;
    checks++; if (ob.exRegWrite !== 1'b1) $display("FAIL ldi_exec_regwrite: got %b want 1", ob.exRegWrite); else passes++;
    checks++; if (ob.exDest !== 2'b00) $display("FAIL ldi_dest: got %b want 00", ob.exDest); else passes++;
    checks++; if (ob.exDataIn !== 8'h5A) $display("FAIL ldi_datain: got %h want 5a", ob.exDataIn); else passes++;
    checks++; if (ob.exRx !== 3'd2) $display("FAIL ldi_rx: got %0d want 2", ob.exRx); else passes++;
    checks++; if (ob.afterRegWrite !== 1'b0) $display("FAIL ldi_regwrite_drop: got %b want 0", ob.afterRegWrite); else passes++;
    checks++; if (ob.afterPc !== 8'h01) $display("FAIL ldi_pc: got %h want 01", ob.afterPc); else passes++;
    checks++; if (ob.afterRetired !== 16'd1) $display("FAIL ldi_retired: got %0d want 1", ob.afterRetired); else passes++;
    mdlPc = 1; mdlRetired = 1;
  endtask

  task automatic test_alu();
    obsT ob;
    doInstr(16'h3290, 0, 8'($urandom), ob);
    checks++; if ({ob.exRx, ob.exRy, ob.exSelOp} !== {3'd1, 3'd2, 3'b010}) $display("FAIL alu_selects: got %b want 001010010", {ob.exRx, ob.exRy, ob.exSelOp}); else passes++;
    checks++; if ({ob.exDest, ob.exRegWrite} !== {2'b10, 1'b1}) $display("FAIL alu_dest_we: got %b want 101", {ob.exDest, ob.exRegWrite}); else passes++;
    mdlPc = mdlPc + 1; mdlRetired = mdlRetired + 1;
    checks++; if (ob.afterRetired !== 16'(mdlRetired)) $display("FAIL alu_retired: got %0d want %0d", ob.afterRetired, mdlRetired); else passes++;
    checks++; if (ob.afterPc !== 8'(mdlPc)) $display("FAIL alu_pc: got %0h want %0h", ob.afterPc, mdlPc); else passes++;
  endtask

  task automatic test_jz();
    obsT ob;
    doInstr(16'h5640, 0, 8'h00, ob);
    checks++; if ({ob.exDest, ob.exRegWrite} !== {2'b11, 1'b0}) $display("FAIL jz_dest_we: got %b want 110", {ob.exDest, ob.exRegWrite}); else passes++;
    checks++; if (ob.afterPc !== 8'h40) $display("FAIL jz_taken_pc: got %h want 40", ob.afterPc); else passes++;
    mdlPc = 'h40; mdlRetired++;
    doInstr(16'h5640, 0, 8'h07, ob);
    checks++; if (ob.exRegWrite !== 1'b0) $display("FAIL jz_nt_regwrite: got %b want 0", ob.exRegWrite); else passes++;
    checks++; if (ob.afterPc !== 8'h41) $display("FAIL jz_not_taken_pc: got %h want 41", ob.afterPc); else passes++;
    mdlPc = 'h41; mdlRetired++;
  endtask

  task automatic test_fetch_stall();
    obsT ob;
    doInstr(16'h4020, 0, 8'h00, ob);
    checks++; if (ob.afterPc !== 8'h20) $display("FAIL jmp_pc: got %h want 20", ob.afterPc); else passes++;
    mdlPc = 'h20; mdlRetired++;
    pulseStart();
    checks++; if ({fetch_req, pc} !== {1'b1, 8'h20}) $display("FAIL start_while_busy: got %h want 120", {fetch_req, pc}); else passes++;
    doInstr(16'h0000, 5, 8'h00, ob);
    checks++; if (ob.stallOk !== 1'b1) $display("FAIL stall_stable: got %b want 1", ob.stallOk); else passes++;
    checks++; if (ob.decFetchReq !== 1'b0) $display("FAIL stall_req_drop: got %b want 0", ob.decFetchReq); else passes++;
    checks++; if (ob.afterPc !== 8'h21) $display("FAIL stall_pc: got %h want 21", ob.afterPc); else passes++;
    mdlPc = 'h21; mdlRetired++;
  endtask

  task automatic test_pc_wrap();
    obsT ob;
    doInstr(16'h40FF, 0, 8'h00, ob);
    doInstr(16'h0000, 0, 8'h00, ob);
    checks++; if (ob.afterPc !== 8'h00) $display("FAIL pc_wrap: got %h want 00", ob.afterPc); else passes++;
    doInstr(16'h9000, 0, 8'h00, ob);
    checks++; if ({ob.exIllegal, ob.exRegWrite} !== 2'b10) $display("FAIL illegal_exec: got %b want 10", {ob.exIllegal, ob.exRegWrite}); else passes++;
    checks++; if (ob.afterIllegal !== 1'b0) $display("FAIL illegal_pulse_width: got %b want 0", ob.afterIllegal); else passes++;
    checks++; if (ob.afterPc !== 8'h01) $display("FAIL illegal_pc: got %h want 01", ob.afterPc); else passes++;
    mdlPc = 1; mdlRetired += 3;
    checks++; if (ob.afterRetired !== 16'(mdlRetired)) $display("FAIL illegal_retired: got %0d want %0d", ob.afterRetired, mdlRetired); else passes++;
  endtask

  task automatic test_random();
    obsT ob;
    for (int n = 0; n < 40; n++) begin
      int op = int'($urandom_range(0, 14));
      logic [15:0] ins = 16'(op * 4096) | 16'($urandom_range(0, 4095));
      int stall = int'($urandom_range(0, 3));
      logic [7:0] dw = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      int expPc = expNextPc(ins, mdlPc, dw);
      doInstr(ins, stall, dw, ob);
      mdlRetired = (mdlRetired + 1) % 65536;
      checks++; if ({ob.timeout, ob.stallOk} !== 2'b01) $display("FAIL rnd_fetch[%0d]: got %b want 01", n, {ob.timeout, ob.stallOk}); else passes++;
      checks++; if (ob.afterPc !== 8'(expPc)) $display("FAIL rnd_pc[%0d] ins=%h: got %h want %h", n, ins, ob.afterPc, expPc); else passes++;
      checks++; if (ob.exRegWrite !== 1'(expWrites(opOf(ins)))) $display("FAIL rnd_regwrite[%0d] ins=%h: got %b", n, ins, ob.exRegWrite); else passes++;
      checks++; if (ob.exDest !== 2'(expDest(opOf(ins)))) $display("FAIL rnd_dest[%0d] ins=%h: got %b want %0d", n, ins, ob.exDest, expDest(opOf(ins))); else passes++;
      checks++; if (ob.exIllegal !== 1'(expIllegal(opOf(ins)))) $display("FAIL rnd_illegal[%0d] ins=%h: got %b", n, ins, ob.exIllegal); else passes++;
      checks++; if (ob.afterRetired !== 16'(mdlRetired)) $display("FAIL rnd_retired[%0d]: got %0d want %0d", n, ob.afterRetired, mdlRetired); else passes++;
      if (expWrites(op) == 1) begin
        checks++; if (ob.exRx !== 3'((int'(ins) / 512) % 8)) $display("FAIL rnd_rx[%0d] ins=%h: got %0d", n, ins, ob.exRx); else passes++;
      end
      if (op == 1) begin
        checks++; if (ob.exDataIn !== 8'(int'(ins) % 256)) $display("FAIL rnd_imm[%0d] ins=%h: got %h", n, ins, ob.exDataIn); else passes++;
      end
      if (op == 3) begin
        checks++; if ({ob.exRy, ob.exSelOp} !== 6'(((int'(ins) / 64) % 8) * 8 + (int'(ins) / 8) % 8)) $display("FAIL rnd_alu[%0d] ins=%h: got %b", n, ins, {ob.exRy, ob.exSelOp}); else passes++;
      end
      mdlPc = expPc;
    end
  endtask

  task automatic test_halt();
    obsT ob;
    doInstr(16'hF000, 1, 8'h00, ob);
    mdlRetired++;
    checks++; if ({ob.afterHalted, ob.afterFetchReq} !== 2'b10) $display("FAIL halt_status: got %b want 10", {ob.afterHalted, ob.afterFetchReq}); else passes++;
    checks++; if (ob.afterPc !== 8'(mdlPc)) $display("FAIL halt_pc: got %h want %h", ob.afterPc, mdlPc); else passes++;
    checks++; if (ob.afterRetired !== 16'(mdlRetired)) $display("FAIL halt_retired: got %0d want %0d", ob.afterRetired, mdlRetired); else passes++;
    repeat (3) step();
    checks++; if ({halted, fetch_req, busy} !== 3'b100) $display("FAIL halt_stays: got %b want 100", {halted, fetch_req, busy}); else passes++;
    pulseStart();
    checks++; if ({fetch_req, busy, halted, pc} !== {3'b110, 8'h00}) $display("FAIL halt_restart: got %h want 600", {fetch_req, busy, halted, pc}); else passes++;
    mdlPc = 0;
    doInstr(16'h0000, 0, 8'h00, ob);
    checks++; if (ob.afterPc !== 8'h01) $display("FAIL restart_pc: got %h want 01", ob.afterPc); else passes++;
    mdlPc = 1; mdlRetired++;
  endtask

  task automatic test_reset_mid_execute();
    instr = 16'h1A77;
    fetch_ack = 1'b1;
    step();
    fetch_ack = 1'b0;
    step();
    checks++; if (regWrite !== 1'b1) $display("FAIL midreset_pre_regwrite: got %b want 1", regWrite); else passes++;
    #2 reset = 1'b1;
    #1;
    checks++; if ({regWrite, busy, fetch_req, destSrc, dataIn, pc, retired} !== 37'h0) $display("FAIL midreset_async: got %h want 0", {regWrite, busy, fetch_req, destSrc, dataIn, pc, retired}); else passes++;
    step();
    reset = 1'b0;
    repeat (2) step();
    checks++; if ({fetch_req, busy, halted, regWrite} !== 4'b0000) $display("FAIL midreset_idle: got %b want 0000", {fetch_req, busy, halted, regWrite}); else passes++;
    mdlPc = 0; mdlRetired = 0;
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_alu();
    test_jz();
    test_fetch_stall();
    test_pc_wrap();
    test_random();
    test_halt();
    test_reset_mid_execute();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
